// File: rtl/disp_scan_ctrl.sv
// Multiplexed NDIG-digit 7-seg scan with sequential double-dabble (BIN_W cycles busy), frame-boundary commit.
// No backpressure: value_load is accepted only while busy=0 and is dropped otherwise.
module disp_scan_ctrl #(
    parameter int NDIG        = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] value_in,
    input  logic             value_load,
    output logic             busy,
    output logic [3:0]       digit_num,
    output logic [NDIG-1:0]  an,
    output logic             ovf
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NDIG);
    localparam int KW = $clog2(BIN_W + 1);
    localparam int DW = 4 * NDIG;
    localparam int BW = 4 * (NDIG + 1);

    logic [CW-1:0]    r_ref_cnt;
    logic [IW-1:0]    r_idx;
    logic [DW-1:0]    r_disp;
    logic             r_ovf;
    logic [DW-1:0]    r_pend;
    logic             r_pend_ovf;
    logic             r_pend_vld;
    logic             r_busy;
    logic [BIN_W-1:0] r_shift;
    logic [BW-1:0]    r_bcd;
    logic [KW-1:0]    r_cnt;
    logic             r_sat;

    logic             w_tick;
    logic             w_frame;
    logic             w_done;
    logic             w_too_big;
    logic [BW-1:0]    w_bcd_adj;
    logic [BW-1:0]    w_bcd_next;
    logic [NDIG-1:0]  w_blank;
    logic             w_hi_zero;

    assign w_tick  = (r_ref_cnt == CW'(REFRESH_DIV - 1));
    assign w_frame = w_tick && (r_idx == IW'(NDIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
        end else if (w_tick) begin
            r_ref_cnt <= '0;
            r_idx     <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_ref_cnt <= r_ref_cnt + CW'(1);
        end
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NDIG + 1; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_next = {w_bcd_adj[BW-2:0], r_shift[BIN_W-1]};
    assign w_done     = r_busy && (r_cnt == KW'(1));
    // r_sat catches bits lost off the top digit when BIN_W exceeds NDIG+1 decimal digits
    assign w_too_big  = (w_bcd_next[BW-1 -: 4] != 4'd0) || r_sat || w_bcd_adj[BW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else if (!r_busy && value_load) begin
            r_busy  <= 1'b1;
            r_shift <= value_in;
            r_bcd   <= '0;
            r_cnt   <= KW'(BIN_W);
            r_sat   <= 1'b0;
        end else if (r_busy) begin
            r_bcd   <= w_bcd_next;
            r_shift <= {r_shift[BIN_W-2:0], 1'b0};
            r_cnt   <= r_cnt - KW'(1);
            r_sat   <= r_sat | w_bcd_adj[BW-1];
            if (r_cnt == KW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // A completion landing on the boundary edge sets pend_vld after the commit sampled it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp     <= '0;
            r_ovf      <= 1'b0;
            r_pend     <= '0;
            r_pend_ovf <= 1'b0;
            r_pend_vld <= 1'b0;
        end else begin
            if (w_frame && r_pend_vld) begin
                r_disp     <= r_pend;
                r_ovf      <= r_pend_ovf;
                r_pend_vld <= 1'b0;
            end
            if (w_done) begin
                r_pend_vld <= 1'b1;
                if (w_too_big) begin
                    r_pend     <= {NDIG{4'h9}};
                    r_pend_ovf <= 1'b1;
                end else begin
                    r_pend     <= w_bcd_next[DW-1:0];
                    r_pend_ovf <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_blank   = '0;
        w_hi_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            w_hi_zero  = w_hi_zero && (r_disp[i*4 +: 4] == 4'd0);
            w_blank[i] = w_hi_zero;
        end
    end

    always_comb begin
        an = '1;
        if (!w_blank[r_idx]) begin
            an[r_idx] = 1'b0;
        end
    end

    assign digit_num = r_disp[{r_idx, 2'b00} +: 4];
    assign busy      = r_busy;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: table of loads with expected BCD/lit masks, scoreboard popped at each commit.
module tb_disp_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int BIN_W = 14;
    localparam int RDIV  = 4;
    localparam int FRAME = NDIG * RDIV;

    typedef struct {
        int          val;
        logic [15:0] bcd;
        logic [3:0]  lit;
        logic        ov;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [BIN_W-1:0] value_in;
    logic             value_load;
    logic             busy;
    logic [3:0]       digit_num;
    logic [NDIG-1:0]  an;
    logic             ovf;

    int   tests;
    int   fails;
    int   k;
    vec_t exp_q[$];
    vec_t cur;
    vec_t vecs[10];

    disp_scan_ctrl #(.NDIG(NDIG), .BIN_W(BIN_W), .REFRESH_DIV(RDIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .value_load (value_load),
        .busy       (busy),
        .digit_num  (digit_num),
        .an         (an),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; slot = (k/RDIV)%NDIG, frame boundary edges at k%FRAME==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", nm, act, exp_v, $time, k);
        end
    endtask

    function automatic logic [3:0] exp_an(input logic [3:0] lit, input int slot);
        logic [3:0] e;
        e = 4'b1111;
        if (lit[slot]) e[slot] = 1'b0;
        return e;
    endfunction

    // Called on the first negedge of slot 0; walks all NDIG slots.
    task automatic check_slots(input logic [15:0] bcd, input logic [3:0] lit, input logic ov);
        for (int j = 0; j < NDIG; j++) begin
            if (j > 0) repeat (RDIV) @(negedge clk);
            chk($sformatf("digit_num[%0d]", j), int'(digit_num), int'(bcd[j*4 +: 4]));
            chk($sformatf("an[%0d]", j), int'(an), int'(exp_an(lit, j)));
            if (j == 0) chk("ovf", int'(ovf), int'(ov));
        end
    endtask

    task automatic wait_boundary(input int kd);
        int n;
        n = 0;
        while (!((k % FRAME == 0) && (k > kd)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL boundary_timeout: got %0d cycles required < 200", n);
        end
    endtask

    task automatic do_load(input int val, input int junk, input vec_t e, output int kd);
        int n;
        int slot;
        value_in   = BIN_W'(val);
        value_load = 1'b1;
        @(negedge clk);
        value_load = 1'b0;
        if (junk > 0) begin
            value_in   = BIN_W'(222);
            value_load = 1'b1;
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n >= junk) value_load = 1'b0;
            @(negedge clk);
        end
        value_load = 1'b0;
        chk($sformatf("busy_cycles(%0d)", val), n, BIN_W);
        kd = k;
        slot = (k / RDIV) % NDIG;
        chk("pre_commit_digit", int'(digit_num), int'(cur.bcd[slot*4 +: 4]));
        chk("pre_commit_an", int'(an), int'(exp_an(cur.lit, slot)));
        // Only one pending value exists: a later completion replaces an uncommitted one.
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_q.push_back(e);
    endtask

    task automatic commit_check(input int kd);
        vec_t e;
        wait_boundary(kd);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = exp_q.pop_front();
            check_slots(e.bcd, e.lit, e.ov);
            cur = e;
        end
    endtask

    initial begin
        int   kd;
        int   kd2;
        int   n;
        vec_t v;

        vecs[0] = '{1234,  16'h1234, 4'b1111, 1'b0};
        vecs[1] = '{7,     16'h0007, 4'b0001, 1'b0};
        vecs[2] = '{1005,  16'h1005, 4'b1111, 1'b0};
        vecs[3] = '{12000, 16'h9999, 4'b1111, 1'b1};
        vecs[4] = '{42,    16'h0042, 4'b0011, 1'b0};
        vecs[5] = '{0,     16'h0000, 4'b0001, 1'b0};
        vecs[6] = '{9999,  16'h9999, 4'b1111, 1'b0};
        vecs[7] = '{10000, 16'h9999, 4'b1111, 1'b1};
        vecs[8] = '{16383, 16'h9999, 4'b1111, 1'b1};
        vecs[9] = '{100,   16'h0100, 4'b0111, 1'b0};

        tests = 0;
        fails = 0;
        cur   = '{0, 16'h0000, 4'b0001, 1'b0};
        rst = 1'b0;
        value_in = '0;
        value_load = 1'b0;

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_an", int'(an), 4'b1110);
        chk("rst_digit", int'(digit_num), 0);
        @(negedge clk);
        rst = 1'b0;
        check_slots(16'h0000, 4'b0001, 1'b0);
        repeat (RDIV) @(negedge clk);
        check_slots(16'h0000, 4'b0001, 1'b0);

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].val, 0, vecs[i], kd);
            commit_check(kd);
        end

        // Load held high with 222 during busy must be dropped.
        v = '{111, 16'h0111, 4'b0111, 1'b0};
        do_load(111, 5, v, kd);
        commit_check(kd);

        // 300 completes on a boundary edge (not committed), then 400 overwrites it.
        n = 0;
        while (k % FRAME != 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        v = '{300, 16'h0300, 4'b0111, 1'b0};
        do_load(300, 0, v, kd);
        chk("done_on_boundary", kd % FRAME, 0);
        v = '{400, 16'h0400, 4'b0111, 1'b0};
        fork
            check_slots(cur.bcd, cur.lit, cur.ov);
            do_load(400, 0, v, kd2);
        join
        commit_check(kd2);

        // Reset in the middle of converting 5678 aborts it.
        value_in   = BIN_W'(5678);
        value_load = 1'b1;
        @(negedge clk);
        value_load = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_an", int'(an), 4'b1110);
        chk("abort_digit", int'(digit_num), 0);
        chk("abort_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        cur = '{0, 16'h0000, 4'b0001, 1'b0};
        repeat (40) @(negedge clk);
        wait_boundary(k);
        check_slots(16'h0000, 4'b0001, 1'b0);
        chk("abort_busy_after", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
